// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the scoreboarded register file
//   DEF_DATA_W   default register width
//   DEF_NREGS    default architectural register count (power of two)
//   DEF_ADDR_W   default register address width
//   DEF_ZERO_REG default index of the hardwired-zero register (XZR)
//   reg_addr_t / reg_data_t  address and data types at the default sizes
package regfile_pkg;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NREGS    = 32;
    localparam int DEF_ADDR_W   = $clog2(DEF_NREGS);
    localparam int DEF_ZERO_REG = DEF_NREGS - 1;
    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending bits, set at issue and cleared at writeback
//   clk, reset_n   clock and asynchronous active-low reset
//   iss_v, iss_a   mark iss_a pending (ignored for the zero register)
//   we, wa         writeback clears wa
//   busy_vec       bit i = register i pending
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int ZERO_REG = NREGS - 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              iss_v,
    input  logic [ADDR_W-1:0] iss_a,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    output logic [NREGS-1:0]  busy_vec
);
    logic [NREGS-1:0] set_m, clr_m;

    always_comb begin
        set_m = '0;
        clr_m = '0;
        if (iss_v && iss_a != ADDR_W'(ZERO_REG)) set_m[iss_a] = 1'b1;
        if (we) clr_m[wa] = 1'b1;
    end

    // OR-ing set after the clear gives a same-cycle issue priority over writeback
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) busy_vec <= '0;
        else          busy_vec <= (busy_vec & ~clr_m) | set_m;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with NRD async read ports, one sync write port,
//             hardwired zero register, optional write-to-read bypass and busy scoreboard
//   clk, reset_n   clock and asynchronous active-low reset
//   ra, rd, rbusy  per-port read address, data and busy flag (port k in slice k)
//   we, wa, wd     write port
//   iss_v, iss_a   issue: mark destination pending
//   busy_vec       full scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREGS    = DEF_NREGS,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = NREGS - 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  iss_v,
    input  logic [ADDR_W-1:0]     iss_a,
    output logic [NREGS-1:0]      busy_vec
);
    logic [DATA_W-1:0] regs [NREGS];

    // Reset preloads each register with its own index; the zero register stays 0
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == ZERO_REG) ? '0 : DATA_W'(i);
        end else if (we && wa != ADDR_W'(ZERO_REG)) begin
            regs[wa] <= wd;
        end

    rf_scoreboard #(.NREGS(NREGS), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .iss_v    (iss_v),
        .iss_a    (iss_a),
        .we       (we),
        .wa       (wa),
        .busy_vec (busy_vec)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              zero, byp;
        assign a    = ra[k*ADDR_W +: ADDR_W];
        assign zero = a == ADDR_W'(ZERO_REG);
        // A bypassed read sees the producer's data, so it is no longer pending
        assign byp  = (BYPASS != 0) && we && wa == a;
        assign rd[k*DATA_W +: DATA_W] = zero ? '0 : byp ? wd : regs[a];
        assign rbusy[k] = !zero && !byp && busy_vec[a];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb with and without bypass
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  ra;
    logic        we, iss_v;
    reg_addr_t   wa, iss_a;
    reg_data_t   wd;
    logic [127:0] rd_b, rd_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic [31:0] busy_b, busy_n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1)) u_b (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a), .busy_vec(busy_b)
    );

    regfile_sb #(.BYPASS(0)) u_n (
        .clk(clk), .reset_n(reset_n), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a), .busy_vec(busy_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra = {5'(a1), 5'(a0)};
    endtask

    task automatic edge_then_idle;
        @(posedge clk);
        #1;
        we = 1'b0;
        iss_v = 1'b0;
        #1;
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; iss_v = 1'b0; wa = '0; iss_a = '0; wd = '0;
        set_ra(0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        // 1: reset contents
        set_ra(5, 30);
        #1;
        check("rst_rd0", rd_b[63:0], 64'd5);
        check("rst_rd1", rd_b[127:64], 64'd30);
        check("rst_rbusy", 64'(rbusy_b), 64'd0);
        check("rst_busy", 64'(busy_b), 64'd0);
        set_ra(31, 30);
        #1;
        check("xzr_rd0", rd_b[63:0], 64'd0);
        // 2: bypass vs no bypass
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 64'hDEAD_BEEF; set_ra(7, 30);
        #1;
        check("byp_rd0", rd_b[63:0], 64'hDEAD_BEEF);
        check("nobyp_rd0_old", rd_n[63:0], 64'd7);
        edge_then_idle();
        check("byp_rd0_after", rd_b[63:0], 64'hDEAD_BEEF);
        check("nobyp_rd0_after", rd_n[63:0], 64'hDEAD_BEEF);
        check("nonbusy_write_busy", 64'(busy_b), 64'd0);
        // 3: zero register ignores writes and issues
        @(negedge clk);
        we = 1'b1; wa = 5'd31; wd = 64'hFFFF; set_ra(31, 30);
        #1;
        check("xzr_nobypass", rd_b[63:0], 64'd0);
        edge_then_idle();
        check("xzr_after_write", rd_b[63:0], 64'd0);
        iss_v = 1'b1; iss_a = 5'd31;
        edge_then_idle();
        check("xzr_issue_busy", 64'(busy_b), 64'd0);
        // 4: issue then writeback
        @(negedge clk);
        iss_v = 1'b1; iss_a = 5'd3; set_ra(3, 3);
        #1;
        check("iss_not_yet", 64'(rbusy_b), 64'd0);
        edge_then_idle();
        check("iss_busy_vec", 64'(busy_b), 64'h8);
        check("iss_rbusy", 64'(rbusy_b), 64'd3);
        @(negedge clk);
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 64'd99;
        #1;
        check("wb_byp_rd0", rd_b[63:0], 64'd99);
        check("wb_byp_rbusy", 64'(rbusy_b), 64'd0);
        check("wb_nobyp_rd0", rd_n[63:0], 64'd3);
        check("wb_nobyp_rbusy", 64'(rbusy_n), 64'd3);
        edge_then_idle();
        check("wb_busy_clear", 64'(busy_b), 64'd0);
        check("wb_rd1_same", rd_b[127:64], 64'd99);
        // 5: set has priority over clear
        @(negedge clk);
        iss_v = 1'b1; iss_a = 5'd4; set_ra(4, 30);
        edge_then_idle();
        check("reissue_pre", 64'(busy_b), 64'h10);
        @(negedge clk);
        iss_v = 1'b1; iss_a = 5'd4; we = 1'b1; wa = 5'd4; wd = 64'd42;
        edge_then_idle();
        check("prio_rd0", rd_b[63:0], 64'd42);
        check("prio_busy", 64'(busy_b), 64'h10);
        check("prio_rbusy", 64'(rbusy_b), 64'd1);
        // 6: async reset mid-operation
        @(negedge clk);
        iss_v = 1'b1; iss_a = 5'd9; we = 1'b1; wa = 5'd9; wd = 64'd55; set_ra(9, 4);
        edge_then_idle();
        check("pre_rst_rd0", rd_b[63:0], 64'd55);
        check("pre_rst_busy", 64'(busy_b), 64'h210);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy_b), 64'd0);
        check("arst_rd0", rd_b[63:0], 64'd9);
        check("arst_rd1", rd_b[127:64], 64'd4);
        set_ra(10, 10);
        we = 1'b1; wa = 5'd9; wd = 64'd77; iss_v = 1'b1; iss_a = 5'd9;
        edge_then_idle();
        @(negedge clk);
        reset_n = 1'b1;
        set_ra(9, 9);
        #1;
        check("rst_write_dropped", rd_b[63:0], 64'd9);
        check("rst_issue_dropped", 64'(busy_b), 64'd0);
        check("same_addr_ports", rd_b[127:64], 64'd9);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor of the ARMv8 integer register file for the pipelined datapath.
- Ports: NRD asynchronous read ports, one synchronous write port, a hardwired zero register, optional write-to-read bypass.
- Holds a per-register busy scoreboard: the decode stage marks a destination pending at issue, and writeback clears it.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
DATA_W, 64, register width in bits
NREGS, 32, number of architectural registers (power of two)
ADDR_W, $clog2(NREGS), register address width
NRD, 2, number of read ports (1..4)
ZERO_REG, NREGS-1, index of the hardwired-zero register (XZR)
BYPASS, 1, 1 = a read of the register being written this cycle returns the write data

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
ra  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd  out  NRD*DATA_W  read data, port k packed as for ra
rbusy  out  NRD  per-port busy flag of the addressed register
we  in  1  write enable
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
iss_v  in  1  issue valid: mark iss_a pending
iss_a  in  ADDR_W  destination register being issued
busy_vec  out  NREGS  full scoreboard, bit i = register i pending

Behaviour:
Reset (reset_n low, asynchronous, takes effect immediately)
- regs[i] = i for i != ZERO_REG.
- All busy bits = 0.
- Outputs follow combinationally from this reset state.

Read (combinational, zero latency)
- ra_k == ZERO_REG -> rd_k = 0, rbusy_k = 0, always.
- BYPASS=1, we=1, wa == ra_k != ZERO_REG -> rd_k = wd and rbusy_k = 0 in the same cycle.
- Otherwise rd_k = regs[ra_k] and rbusy_k = busy[ra_k].
- BYPASS=0 -> rd_k shows the old value until the next edge.

Write (rising clk)
- we=1 and wa != ZERO_REG -> regs[wa] <= wd.
- we=1 and wa == ZERO_REG -> ignored; no state change.

Scoreboard (rising clk, per register i)
- set = iss_v && iss_a==i && i!=ZERO_REG.
- clr = we && wa==i.
- set=1 -> busy[i] <= 1. Set has priority over clr: a new producer issued in the same cycle the old one writes back keeps the register pending.
- clr=1 and set=0 -> busy[i] <= 0.
- Neither -> busy[i] holds.
- busy[ZERO_REG] is constant 0.

Boundary conditions
- Writing a register that is not busy is legal and does not alter busy.
- Issuing to an already-busy register is legal; busy stays 1.
- Read ports with identical addresses return identical data.
- Reset asserted mid-operation: state reinitialises immediately; an in-flight write or issue at a coincident edge is discarded.
- Reset deassertion is synchronised externally; no internal synchroniser.
- Out-of-range addresses cannot occur (NREGS = 2^ADDR_W).

Decomposition:
- Shared package regfile_pkg: DATA_W, NREGS, ADDR_W defaults, ZERO_REG index; typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]).
- Sub-module rf_scoreboard holds the busy bit vector: inputs iss_v/iss_a/we/wa, output busy_vec.
- regfile_sb instantiates rf_scoreboard once and generates the NRD read-port muxes with a for-generate loop.

Test Plan:
1. Reset, then read ra0=5, ra1=30 -> rd0=5, rd1=30, rbusy=00, busy_vec=0; ra0=31 -> rd0=0.
2. we=1, wa=7, wd=64'hDEAD_BEEF, ra0=7, BYPASS=1 -> rd0=DEADBEEF in the same cycle. After the edge with we=0 -> rd0 still DEADBEEF. Same test with BYPASS=0 -> rd0=7 before the edge, DEADBEEF after.
3. we=1, wa=31, wd=64'hFFFF -> after the edge ra0=31 reads 0. iss_v=1, iss_a=31 -> busy_vec[31]=0.
4. iss_v=1, iss_a=3 at cycle n -> busy_vec[3]=1 and rbusy0=1 (ra0=3) from n+1. we=1, wa=3, wd=99 at cycle n+2 -> rd0=99 and rbusy0=0 combinationally (BYPASS=1); busy[3]=0 from n+3.
5. Busy register 4, then iss_v=1, iss_a=4, we=1, wa=4, wd=42 in the same cycle -> after the edge regs[4]=42 and busy[4]=1 (set priority).
6. Busy register 9 and write regs[9]=55; assert reset_n=0 between edges -> immediately busy_vec=0 and rd(ra=9)=9; hold reset_n=0 across an edge with we=1, wa=9 -> the write is discarded.
